// File: rtl/tulip_fp_pkg.sv
// Shared single-precision float definitions for the tulip datapath
// (int_to_float_stream, polynomial_estimator).
package tulip_fp_pkg;

    localparam int unsigned C_FP_DWIDTH     = 32;
    localparam int unsigned C_FP_EXP_BIAS   = 127;
    localparam int unsigned C_FP_MANT_WIDTH = 23;
    localparam int unsigned C_FP_EXP_WIDTH  = 8;

    typedef logic [C_FP_DWIDTH-1:0] float_t;

    typedef struct packed {
        logic                       sign;
        logic [C_FP_EXP_WIDTH-1:0]  exponent;
        logic [C_FP_MANT_WIDTH-1:0] mantissa;
    } float_fields_t;

    // Width of a bit-position index into a vector of w bits (at least 1).
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/leading_one_detector.sv
// Combinational leading-one detector: position of the highest set bit
// of value, plus a flag for an all-zero value.
module leading_one_detector
    import tulip_fp_pkg::*;
#(
    parameter int unsigned G_WIDTH = 24,
    localparam int unsigned IDX_W  = idx_width(G_WIDTH)
) (
    input  logic [G_WIDTH-1:0] value,
    output logic [IDX_W-1:0]   msb_index,
    output logic               zero
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        msb_index = '0;
        for (int unsigned i = 0; i < G_WIDTH; i++) begin
            if (value[i]) begin
                msb_index = IDX_W'(i);
            end
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/int_to_float_stream.sv
// Streaming signed fixed-point to IEEE-754 single-precision converter.
// One sample in flight; exact conversion through a five-state sequence.
module int_to_float_stream
    import tulip_fp_pkg::*;
#(
    parameter int unsigned G_IN_DWIDTH = 24,
    parameter int unsigned G_FRAC_BITS = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [G_IN_DWIDTH-1:0] din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output float_t                 dout,
    output logic                   dout_valid,
    input  logic                   dout_ready
);

    localparam int unsigned IDX_W      = idx_width(G_IN_DWIDTH);
    localparam int unsigned MANT_EXT_W = C_FP_MANT_WIDTH + 1;
    localparam int unsigned SHIFT_W    = $clog2(MANT_EXT_W);
    localparam logic [C_FP_EXP_WIDTH-1:0] EXP_BASE =
        C_FP_EXP_WIDTH'(C_FP_EXP_BIAS - G_FRAC_BITS);

    localparam logic [2:0] SM_GET_INPUT   = 3'd0;
    localparam logic [2:0] SM_MAGNITUDE   = 3'd1;
    localparam logic [2:0] SM_NORMALIZE   = 3'd2;
    localparam logic [2:0] SM_PACK        = 3'd3;
    localparam logic [2:0] SM_SEND_OUTPUT = 3'd4;

    logic [2:0]               state_q;
    logic [2:0]               state_d;
    logic                     accept;
    logic [G_IN_DWIDTH-1:0]   din_q;
    logic                     sign_q;
    logic [G_IN_DWIDTH-1:0]   mag_q;
    logic [IDX_W-1:0]         msb_idx_q;
    logic                     zero_q;
    logic [IDX_W-1:0]         lod_idx;
    logic                     lod_zero;
    float_t                   dout_q;
    logic [MANT_EXT_W-1:0]    mag_norm;
    logic [SHIFT_W-1:0]       shift_amt;
    float_fields_t            fields;

    // Next state and handshake outputs; enable and reset gate the handshakes
    // so nothing is offered in a cycle where it would be thrown away.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        if (!enable) begin
            state_d = SM_GET_INPUT;
        end else begin
            case (state_q)
                SM_GET_INPUT: begin
                    din_ready = ~reset;
                    if (din_valid) begin
                        accept  = 1'b1;
                        state_d = SM_MAGNITUDE;
                    end
                end
                SM_MAGNITUDE:  state_d = SM_NORMALIZE;
                SM_NORMALIZE:  state_d = SM_PACK;
                SM_PACK:       state_d = SM_SEND_OUTPUT;
                SM_SEND_OUTPUT: begin
                    dout_valid = ~reset;
                    if (dout_ready) begin
                        state_d = SM_GET_INPUT;
                    end
                end
                default:       state_d = SM_GET_INPUT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SM_GET_INPUT;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            if (enable && (state_q == SM_PACK)) begin
                dout_q <= zero_q ? float_t'(0) : float_t'(fields);
            end
        end
    end

    // Datapath stages; the FSM decides when their contents are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            din_q <= din;
        end
        if (state_q == SM_MAGNITUDE) begin
            sign_q <= din_q[G_IN_DWIDTH-1];
            mag_q  <= din_q[G_IN_DWIDTH-1] ? ((~din_q) + G_IN_DWIDTH'(1)) : din_q;
        end
        if (state_q == SM_NORMALIZE) begin
            msb_idx_q <= lod_idx;
            zero_q    <= lod_zero;
        end
    end

    leading_one_detector #(
        .G_WIDTH (G_IN_DWIDTH)
    ) u_lod (
        .value     (mag_q),
        .msb_index (lod_idx),
        .zero      (lod_zero)
    );

    // Shift the leading one up to the hidden-bit position; the bits below it
    // become the mantissa, zero-filled from the right.
    always_comb begin
        shift_amt       = SHIFT_W'(C_FP_MANT_WIDTH) - SHIFT_W'(msb_idx_q);
        mag_norm        = MANT_EXT_W'(mag_q) << shift_amt;
        fields.sign     = sign_q;
        fields.exponent = EXP_BASE + C_FP_EXP_WIDTH'(msb_idx_q);
        fields.mantissa = mag_norm[C_FP_MANT_WIDTH-1:0];
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_int_to_float_stream.sv
// Directed bench for int_to_float_stream: vector table plus hand-written
// backpressure, streaming, abort and reset sequences; second instance at 16.0.
module tb_int_to_float_stream;
    import tulip_fp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] din;
    logic        din_valid;
    logic        din_ready;
    float_t      dout;
    logic        dout_valid;
    logic        dout_ready;

    logic [15:0] din16;
    logic        din_valid16;
    logic        din_ready16;
    float_t      dout16;
    logic        dout_valid16;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [23:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    int_to_float_stream #(
        .G_IN_DWIDTH (24),
        .G_FRAC_BITS (23)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    int_to_float_stream #(
        .G_IN_DWIDTH (16),
        .G_FRAC_BITS (0)
    ) dut16 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .din        (din16),
        .din_valid  (din_valid16),
        .din_ready  (din_ready16),
        .dout       (dout16),
        .dout_valid (dout_valid16),
        .dout_ready (dout_ready)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer d to one instance, then measure edges from acceptance to transfer.
    task automatic run_vec(input bit sel, input logic [23:0] d, input logic [31:0] exp_val,
                           input string nm);
        logic        rdy;
        logic [31:0] got;
        int          guard;
        int          lat;
        bit          seen;
        if (sel) begin
            din16       = d[15:0];
            din_valid16 = 1'b1;
        end else begin
            din       = d;
            din_valid = 1'b1;
        end
        guard = 0;
        rdy   = sel ? din_ready16 : din_ready;
        while (!rdy && guard < 20) begin
            tick();
            guard++;
            rdy = sel ? din_ready16 : din_ready;
        end
        check({nm, " accept"}, 32'(rdy), 32'd1);
        tick();
        din_valid   = 1'b0;
        din_valid16 = 1'b0;
        seen = 1'b0;
        lat  = 0;
        got  = '0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            if (sel ? dout_valid16 : dout_valid) begin
                seen = 1'b1;
                lat  = k;
                got  = sel ? dout16 : dout;
            end
            tick();
        end
        check({nm, " latency"}, 32'(lat), 32'd4);
        check({nm, " dout"}, got, exp_val);
    endtask

    task automatic accept_main(input logic [23:0] d, input string nm);
        int guard;
        din       = d;
        din_valid = 1'b1;
        guard     = 0;
        while (!din_ready && guard < 20) begin
            tick();
            guard++;
        end
        check({nm, " accept"}, 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int guard;
        guard = 0;
        while (!dout_valid && guard < 10) begin
            tick();
            guard++;
        end
        check({nm, " dout_valid"}, 32'(dout_valid), 32'd1);
    endtask

    initial begin
        int acc_t[$];
        int out_t[$];
        bit quiet;

        reset       = 1'b1;
        enable      = 1'b1;
        din         = '0;
        din_valid   = 1'b0;
        din16       = '0;
        din_valid16 = 1'b0;
        dout_ready  = 1'b1;
        repeat (3) tick();
        check("reset din_ready", 32'(din_ready), 32'd0);
        check("reset dout_valid", 32'(dout_valid), 32'd0);
        check("reset dout", dout, 32'h0000_0000);
        check("reset dout16", dout16, 32'h0000_0000);
        reset = 1'b0;
        #1;
        check("post-reset din_ready", 32'(din_ready), 32'd1);

        vecs[0] = '{24'h400000, 32'h3F00_0000};
        vecs[1] = '{24'h800000, 32'hBF80_0000};
        vecs[2] = '{24'hC00000, 32'hBF00_0000};
        vecs[3] = '{24'h000001, 32'h3400_0000};
        vecs[4] = '{24'h7FFFFF, 32'h3F7F_FFFE};
        vecs[5] = '{24'h000000, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            run_vec(1'b0, vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));
        end

        // Backpressure: output held stable while downstream stalls.
        dout_ready = 1'b0;
        accept_main(24'h400000, "bp");
        wait_valid("bp");
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp hold%0d dout", c), dout, 32'h3F00_0000);
            check($sformatf("bp hold%0d hs", c), 32'({dout_valid, din_ready}), 32'd2);
            tick();
        end
        dout_ready = 1'b1;
        tick();
        check("bp released dout_valid", 32'(dout_valid), 32'd0);
        check("bp released din_ready", 32'(din_ready), 32'd1);

        // Continuous input: one accept every 5 cycles, 4-edge latency.
        din       = 24'h200000;
        din_valid = 1'b1;
        for (int t = 0; t < 45; t++) begin
            if (t == 32) din_valid = 1'b0;
            if (din_valid && din_ready) acc_t.push_back(t);
            if (dout_valid) begin
                out_t.push_back(t);
                check($sformatf("stream dout t%0d", t), dout, 32'h3E80_0000);
            end
            tick();
        end
        check("stream accepts", 32'(acc_t.size()), 32'd7);
        check("stream outputs", 32'(out_t.size()), 32'(acc_t.size()));
        for (int i = 1; i < acc_t.size(); i++) begin
            check($sformatf("stream spacing%0d", i), 32'(acc_t[i] - acc_t[i-1]), 32'd5);
        end
        for (int i = 0; i < out_t.size() && i < acc_t.size(); i++) begin
            check($sformatf("stream latency%0d", i), 32'(out_t[i] - acc_t[i]), 32'd4);
        end

        // Enable dropped while the sample sits in SM_NORMALIZE.
        accept_main(24'h400000, "abort");
        tick();
        enable = 1'b0;
        #1;
        check("abort hs0", 32'({dout_valid, din_ready}), 32'd0);
        tick();
        check("abort hs1", 32'({dout_valid, din_ready}), 32'd0);
        tick();
        enable = 1'b1;
        #1;
        quiet = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (dout_valid) quiet = 1'b0;
            tick();
        end
        check("abort no output", 32'(quiet), 32'd1);
        run_vec(1'b0, 24'hC00000, 32'hBF00_0000, "after abort");

        // Reset pulse while the result is waiting in SM_SEND_OUTPUT.
        dout_ready = 1'b0;
        accept_main(24'h400000, "rst");
        wait_valid("rst");
        reset = 1'b1;
        tick();
        check("rst dout_valid", 32'(dout_valid), 32'd0);
        check("rst dout", dout, 32'h0000_0000);
        check("rst held din_ready", 32'(din_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst released din_ready", 32'(din_ready), 32'd1);
        dout_ready = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (dout_valid) quiet = 1'b0;
            tick();
        end
        check("rst no output", 32'(quiet), 32'd1);
        check("rst idle din_ready", 32'(din_ready), 32'd1);

        // 16-bit integer instance.
        run_vec(1'b1, 24'h008000, 32'hC700_0000, "w16 min");
        run_vec(1'b1, 24'h000003, 32'h4040_0000, "w16 three");
        run_vec(1'b1, 24'h00FFFD, 32'hC040_0000, "w16 minus3");
        run_vec(1'b1, 24'h000001, 32'h3F80_0000, "w16 one");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, expected completion before 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/int_to_float_stream.md
INT_TO_FLOAT_STREAM -- requirements
Module: int_to_float_stream

Interface
REQ-001 Parameter G_IN_DWIDTH, default 24: width of the signed two's-complement input sample; legal range 2..24, so conversion is always exact.
REQ-002 Parameter G_FRAC_BITS, default 23: number of fractional bits in din; output value = din / 2^G_FRAC_BITS; legal range 0..G_IN_DWIDTH-1.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  1 = run; 0 = abort and hold idle.
REQ-006 din  in  G_IN_DWIDTH  signed fixed-point sample.
REQ-007 din_valid  in  1  din is valid.
REQ-008 din_ready  out  1  block can accept din.
REQ-009 dout  out  32  IEEE-754 single-precision result.
REQ-010 dout_valid  out  1  dout is valid.
REQ-011 dout_ready  in  1  downstream (polynomial estimator) accepts dout.

Function
REQ-012 FSM states, in order: SM_GET_INPUT, SM_MAGNITUDE, SM_NORMALIZE, SM_PACK, SM_SEND_OUTPUT.
REQ-013 SM_GET_INPUT: din_ready=1; on din_valid=1, register din and go to SM_MAGNITUDE; otherwise stay.
REQ-014 SM_MAGNITUDE: register sign = din MSB and magnitude = |din| in G_IN_DWIDTH unsigned bits (most-negative input gives 2^(G_IN_DWIDTH-1)); go to SM_NORMALIZE.
REQ-015 SM_NORMALIZE: register msb_index = position of the highest set bit of the magnitude, plus a zero flag; go to SM_PACK.
REQ-016 SM_PACK: form the result and go to SM_SEND_OUTPUT.
  - Normal case: exponent = 127 + msb_index - G_FRAC_BITS.
  - Mantissa: the magnitude bits below msb_index, left-aligned into 23 bits and zero-filled.
  - Zero magnitude: result 0x00000000 (positive zero).
REQ-017 SM_SEND_OUTPUT: dout_valid=1 and dout stable; on dout_ready=1 go to SM_GET_INPUT; otherwise hold dout and dout_valid.
REQ-018 din_ready=1 only in SM_GET_INPUT; dout_valid=1 only in SM_SEND_OUTPUT; the two are never 1 in the same cycle.
REQ-019 Latency: transfer accepted on edge N gives dout_valid=1 from edge N+4; minimum spacing between accepted inputs is 5 cycles.
REQ-020 Conversion is exact; no rounding, denormal, infinity or NaN outputs occur within legal parameters.
REQ-021 enable=0 in any state: next state SM_GET_INPUT; any in-flight sample is discarded; din_ready=0 and dout_valid=0 while enable=0.
REQ-022 dout is don't-care while dout_valid=0, but it shall hold its value until the next SM_PACK.

Reset
REQ-023 reset=1 at an edge: state := SM_GET_INPUT; dout := 0x00000000; din_ready and dout_valid read 0 in the cycle after reset while reset is held.
REQ-024 Reset has priority over enable.
REQ-025 Reset during any state discards the in-flight sample; no dout_valid pulse follows reset deassertion until a new input is accepted.

Structure
REQ-026 Shared package tulip_fp_pkg holds: typedef float_t (logic [31:0]), C_FP_DWIDTH=32, C_FP_EXP_BIAS=127, C_FP_MANT_WIDTH=23. The package is also imported by polynomial_estimator.
REQ-027 Sub-module leading_one_detector.
  - Parameterised by width.
  - Combinational: magnitude in; msb_index and zero flag out.
  - Its outputs are registered in SM_NORMALIZE.
REQ-028 The state type is local to int_to_float_stream; target size is 120-250 lines of RTL.

Verification
REQ-029 Defaults, dout_ready=1; feed din = 0x400000, 0x800000, 0xC00000, 0x000001, 0x7FFFFF, 0x000000 -> dout = 0x3F000000, 0xBF800000, 0xBF000000, 0x34000000, 0x3F7FFFFE, 0x00000000, each exactly 4 edges after acceptance.
REQ-030 din=0x400000 accepted, dout_ready held 0 for 10 cycles -> dout_valid=1 and dout=0x3F000000 stable throughout; din_ready=0 throughout; one transfer only when dout_ready rises.
REQ-031 din_valid held 1 continuously with 0x200000 -> accepts every 5 cycles; each output = 0x3E800000; no input is lost or duplicated.
REQ-032 Accept 0x400000, drop enable to 0 in SM_NORMALIZE for 2 cycles, then restore -> no dout_valid for that sample; the next input 0xC00000 yields 0xBF000000.
REQ-033 Assert reset for 1 cycle in SM_SEND_OUTPUT -> dout_valid=0 and dout=0x00000000 after the edge; din_ready=1 on the first cycle after reset deasserts.
REQ-034 G_IN_DWIDTH=16, G_FRAC_BITS=0; din=0x8000 -> 0xC7000000 (-32768.0); din=0x0003 -> 0x40400000 (3.0).
